// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, flag bit positions, result entry layout
// and the per-operation flag sanitiser.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_RD_W   = 5;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic [3:0]            flags;
        logic [ALU_RD_W-1:0]   rd;
        logic                  wen;
    } alu_entry_t;

    // Carry and overflow only mean something for arithmetic ops.
    function automatic logic [3:0] sanitise_flags(
        input logic [1:0] ctrl,
        input logic       n,
        input logic       z,
        input logic       c,
        input logic       v
    );
        logic       keep_cv;
        logic [3:0] f;
        keep_cv  = (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
        f        = '0;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        f[FLG_C] = c & keep_cv;
        f[FLG_V] = v & keep_cv;
        return f;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready is a pure flop output so
// there is no combinational path from out_ready back to the producer.
module alu_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_reg, main_valid_next;
    logic         skid_valid_reg, skid_valid_next;
    logic         ready_reg;
    logic [W-1:0] main_data_reg, main_data_next;
    logic [W-1:0] skid_data_reg, skid_data_next;
    logic         accept;
    logic         xfer;

    always_comb begin
        accept          = in_valid && ready_reg;
        xfer            = main_valid_reg && out_ready;
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (!main_valid_reg || xfer) begin
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                skid_valid_next = accept;
                if (accept) skid_data_next = in_data;
            end else begin
                main_valid_next = accept;
                // Main keeps its last value when nothing new arrives.
                if (accept) main_data_next = in_data;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            ready_reg      <= !skid_valid_next;
            main_data_reg  <= main_data_next;
            skid_data_reg  <= skid_data_next;
        end
    end

    assign in_ready  = ready_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

endmodule

// File: rtl/alu_result_stage.sv
// EX->MEM stage after the ALU: sanitises flags, decides writeback, buffers the
// entry through a skid buffer and tracks overflow events.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int RD_W        = 5,
    parameter int CNT_W       = 8,
    parameter bit TRAP_ON_OVF = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_carry,
    input  logic              in_zero,
    input  logic              in_overflow,
    input  logic              in_negative,
    input  logic [1:0]        in_alu_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_flags,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wen,
    input  logic              ovf_clr,
    output logic              ovf_sticky,
    output logic [CNT_W-1:0]  ovf_count
);

    // Same layout as alu_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [3:0]        flags;
        logic [RD_W-1:0]   rd;
        logic              wen;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    entry_t           in_entry;
    entry_t           out_entry;
    logic [3:0]       flags_san;
    logic             ovf_event;
    logic             ovf_accept;
    logic             sticky_reg;
    logic [CNT_W-1:0] count_reg;

    always_comb begin
        flags_san       = sanitise_flags(in_alu_ctrl, in_negative, in_zero,
                                         in_carry, in_overflow);
        ovf_event       = flags_san[FLG_V];
        in_entry.result = in_result;
        in_entry.flags  = flags_san;
        in_entry.rd     = in_rd;
        in_entry.wen    = (in_rd != '0) && !(TRAP_ON_OVF && ovf_event);
        ovf_accept      = in_valid && in_ready && ovf_event;
    end

    alu_skid_buf #(
        .W(ENTRY_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_entry)
    );

    // Clear takes effect before a same-cycle event is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= 1'b0;
            count_reg  <= '0;
        end else if (ovf_clr) begin
            sticky_reg <= ovf_accept;
            count_reg  <= ovf_accept ? CNT_W'(1) : '0;
        end else if (ovf_accept) begin
            sticky_reg <= 1'b1;
            if (count_reg != CNT_MAX) count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign out_result = out_entry.result;
    assign out_flags  = out_entry.flags;
    assign out_rd     = out_entry.rd;
    assign out_wen    = out_entry.wen;
    assign ovf_sticky = sticky_reg;
    assign ovf_count  = count_reg;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- EX→MEM pipeline stage directly downstream of the 32-bit ALU.
- Captures the ALU result, the four flags (carry, zero, overflow, negative), the ALU control code and the destination register.
- Sanitises the flags per operation and decides writeback enable.
- Buffers through a 2-entry skid buffer with valid/ready handshakes, and keeps a sticky overflow flag plus a saturating overflow event counter.

Parameters:
- DATA_W, 32, result width
- RD_W, 5, destination register index width
- CNT_W, 8, overflow event counter width
- TRAP_ON_OVF, 1, when 1 an overflowing add/sub suppresses writeback

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream holds a valid ALU result
- in_ready  out  1  stage can accept this cycle
- in_result  in  DATA_W  ALU Output bus
- in_carry  in  1  ALU CarryOut
- in_zero  in  1  ALU zero
- in_overflow  in  1  ALU overflow
- in_negative  in  1  ALU negative
- in_alu_ctrl  in  2  ALUControl used: 00 add, 01 xor, 10 sub, 11 slt
- in_rd  in  RD_W  destination register
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_result  out  DATA_W  registered result
- out_flags  out  4  {N,Z,C,V} sanitised
- out_rd  out  RD_W  registered destination
- out_wen  out  1  register-file write enable for this entry
- ovf_clr  in  1  synchronous clear of sticky flag and counter
- ovf_sticky  out  1  set by any accepted overflowing add/sub
- ovf_count  out  CNT_W  accepted overflow events, saturating

Behaviour:
- Reset: clk single domain; rst_n asynchronous assert, active low. All outputs 0 during reset. Both buffer entries invalid, ovf_sticky=0, ovf_count=0. in_ready=1 from the first edge after deassertion.
- Accept: an accept occurs when in_valid && in_ready at a rising edge. Transfer occurs when out_valid && out_ready at a rising edge.
- Latency: an accepted entry appears on out_* on the next cycle when the main register is empty or draining. Throughput is 1/cycle while out_ready=1.
- Buffer structure: main register drives out_*. The skid register captures an accepted entry when main is valid and not transferring.
- in_ready: equals !skid_valid and comes directly from a flop. No combinational in→out paths.
- Skid draining: on transfer with skid_valid, skid moves into main. An accept in the same cycle goes into skid.
- Order: strict FIFO order is preserved.
- Flag sanitising, applied at accept:
  - N = in_negative; Z = in_zero.
  - C and V pass through for ctrl 00/10.
  - C and V are forced to 0 for ctrl 01/11.
- ovf_event: V after sanitising.
- out_wen:
  - 0 if rd == 0.
  - 0 if TRAP_ON_OVF=1 and ovf_event.
  - Otherwise 1.
  - Computed at accept and stored with the entry.
- Sticky flag and counter:
  - ovf_sticky sets on an accept with ovf_event.
  - ovf_count increments by 1 on such an accept and holds at 2^CNT_W-1.
- ovf_clr:
  - Clears ovf_sticky and ovf_count.
  - If asserted in the same cycle as an overflowing accept, the result is sticky=1, count=1 (clear then count).
  - ovf_clr does not affect buffered data.
- Full: with both entries valid, in_ready=0. Input fields are ignored even if in_valid=1.
- Empty: out_valid=0. out_* holds the last transferred values. Downstream must not use them.
- Backpressure: while out_valid && !out_ready, out_* is stable.
- Reset mid-operation: both entries are discarded and counters zeroed immediately (asynchronous). No partial entry survives.
- X-safety: out_wen and out_flags are 0 whenever out_valid=0 after reset, until the first accept.

Decomposition:
- Shared package alu_pkg:
  - ALU control constants ALU_ADD=2'b00, ALU_XOR=2'b01, ALU_SUB=2'b10, ALU_SLT=2'b11.
  - Flag bit indices FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
  - A packed entry typedef {result, flags, rd, wen}.
- One sub-module, alu_skid_buf: a generic 2-entry valid/ready skid buffer, parameterised by payload width.
- The top level holds the flag sanitising, wen logic and the overflow counter.

Test Plan:
- Add overflow: ctrl=00, result=0x80000000, V=1, C=0, N=1, rd=5, TRAP_ON_OVF=1, out_ready=1 → next cycle out_valid=1, out_flags=4'b1001, out_wen=0, ovf_sticky=1, ovf_count=1.
- XOR masking: ctrl=01, result=0, carry=1, overflow=1, zero=1, rd=3 → out_flags=4'b0100, out_wen=1, ovf_count unchanged.
- Backpressure: out_ready=0, three back-to-back valid inputs with results 1, 2, 3:
  - in_ready drops after the 2nd accept and the 3rd is held.
  - out_ready=1 then delivers 1, 2, 3 in order on consecutive cycles.
- rd zero: ctrl=10, result=0x7, rd=0 → out_wen=0; sticky untouched.
- Saturation and clear:
  - 300 overflowing subs with CNT_W=8 → ovf_count=255.
  - ovf_clr together with an overflowing accept → ovf_count=1, ovf_sticky=1.
- Async reset: drop rst_n mid-cycle with both entries full → out_valid=0, ovf_count=0 immediately; in_ready=1 after release.
